// File: rtl/data_cache_ctrl.sv
// data_cache_ctrl
//   Direct-mapped, write-through, no-write-allocate L1 data cache between the
//   load/store unit and dataMemory. One request is outstanding at a time.
//   Load hits respond two cycles after accept. Load misses fetch a 512-bit
//   line through dataMemory's address-change/readEnable protocol. Stores
//   update a hit line in place and always go through the
//   writeRequest/writeDone handshake. A store miss never allocates a line.
//
// Ports
//   clock, reset_n   : rising-edge clock, asynchronous active-low reset
//   reqValid/Ready   : LSU request handshake; reqReady is high only in IDLE
//   reqWrite         : 1 = store, 0 = load
//   reqAddr/Wdata    : byte address (bits [1:0] ignored) and store data
//   respValid/Data   : one-cycle response pulse; data is the load word, 0 for stores
//   memReadAddress   : line-aligned fetch address presented to dataMemory
//   memReadEnable    : dataMemory ready flag (0 while a fetch is in progress)
//   memLineIn        : fetched 512-bit line
//   memWrite*        : write-through address, data and request to dataMemory
//   memWriteDone     : dataMemory write-complete flag (0 while busy)
module data_cache_ctrl #(
    parameter int IDX_BITS = 4,
    parameter int TAG_BITS = 26 - IDX_BITS
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         reqValid,
    input  logic         reqWrite,
    input  logic [31:0]  reqAddr,
    input  logic [31:0]  reqWdata,
    output logic         reqReady,
    output logic         respValid,
    output logic [31:0]  respData,
    output logic [31:0]  memReadAddress,
    input  logic         memReadEnable,
    input  logic [511:0] memLineIn,
    output logic [31:0]  memWriteAddress,
    output logic         memWriteRequest,
    output logic [31:0]  memWriteData,
    input  logic         memWriteDone
);
    localparam int LINES = 2 ** IDX_BITS;

    typedef enum logic [3:0] {
        IDLE, LOOKUP, RD_ISSUE, RD_KICK, RD_LOW, RD_HIGH, WR_REQ, WR_LOW, WR_HIGH
    } state_t;

    state_t              state_q, state_d;
    logic                wr_q, wr_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                resp_valid_q, resp_valid_d;
    logic [31:0]         resp_data_q, resp_data_d;
    logic [31:0]         mra_q, mra_d;
    logic [31:0]         mwa_q, mwa_d;
    logic                mwr_q, mwr_d;
    logic [31:0]         mwd_q, mwd_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [TAG_BITS-1:0] tags_q  [LINES];
    logic [511:0]        lines_q [LINES];

    logic [IDX_BITS-1:0] idx;
    logic [TAG_BITS-1:0] tag;
    logic [3:0]          word;
    logic [31:0]         line_addr;
    logic                hit;
    logic                fill_en;
    logic                store_en;

    assign word      = addr_q[5:2];
    assign idx       = addr_q[6+IDX_BITS-1:6];
    assign tag       = addr_q[31:6+IDX_BITS];
    assign line_addr = {addr_q[31:6], 6'd0};
    // Tag array content is meaningless until the valid bit is set.
    assign hit       = valid_q[idx] && (tags_q[idx] == tag);

    assign reqReady        = (state_q == IDLE);
    assign respValid       = resp_valid_q;
    assign respData        = resp_data_q;
    assign memReadAddress  = mra_q;
    assign memWriteAddress = mwa_q;
    assign memWriteRequest = mwr_q;
    assign memWriteData    = mwd_q;

    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        mra_d        = mra_q;
        mwa_d        = mwa_q;
        mwr_d        = mwr_q;
        mwd_d        = mwd_q;
        valid_d      = valid_q;
        fill_en      = 1'b0;
        store_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (reqValid) begin
                    wr_d    = reqWrite;
                    addr_d  = reqAddr;
                    wdata_d = reqWdata;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (wr_q) begin
                    store_en = hit;
                    state_d  = WR_REQ;
                end else if (hit) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = lines_q[idx][{word, 5'd0} +: 32];
                    state_d      = IDLE;
                end else begin
                    state_d = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                // dataMemory only starts a fetch on an address change, so a
                // refetch of the address it already holds needs a detour.
                if (line_addr == mra_q) begin
                    mra_d   = line_addr ^ 32'h40;
                    state_d = RD_KICK;
                end else begin
                    mra_d   = line_addr;
                    state_d = RD_LOW;
                end
            end
            RD_KICK: begin
                mra_d   = line_addr;
                state_d = RD_LOW;
            end
            RD_LOW: begin
                if (!memReadEnable) state_d = RD_HIGH;
            end
            RD_HIGH: begin
                if (memReadEnable) begin
                    fill_en      = 1'b1;
                    valid_d[idx] = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_data_d  = memLineIn[{word, 5'd0} +: 32];
                    state_d      = IDLE;
                end
            end
            WR_REQ: begin
                mwa_d   = addr_q;
                mwd_d   = wdata_q;
                mwr_d   = 1'b1;
                state_d = WR_LOW;
            end
            WR_LOW: begin
                if (!memWriteDone) begin
                    mwr_d   = 1'b0;
                    state_d = WR_HIGH;
                end
            end
            WR_HIGH: begin
                if (memWriteDone) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = 32'd0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            wr_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
            mra_q        <= 32'hFFFF_FFC0;
            mwa_q        <= 32'd0;
            mwr_q        <= 1'b0;
            mwd_q        <= 32'd0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            mra_q        <= mra_d;
            mwa_q        <= mwa_d;
            mwr_q        <= mwr_d;
            mwd_q        <= mwd_d;
            valid_q      <= valid_d;
        end
    end

    // Request payload and line storage carry no reset; valid bits gate them.
    always_ff @(posedge clock) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        if (fill_en) begin
            lines_q[idx] <= memLineIn;
            tags_q[idx]  <= tag;
        end else if (store_en) begin
            lines_q[idx][{word, 5'd0} +: 32] <= wdata_q;
        end
    end
endmodule

// File: tb/tb_data_cache_ctrl.sv
module tb_data_cache_ctrl;
    logic         clock = 1'b0;
    logic         reset_n = 1'b1;
    logic         reqValid = 1'b0;
    logic         reqWrite = 1'b0;
    logic [31:0]  reqAddr = '0;
    logic [31:0]  reqWdata = '0;
    logic         reqReady;
    logic         respValid;
    logic [31:0]  respData;
    logic [31:0]  memReadAddress;
    logic         memReadEnable;
    logic [511:0] memLineIn;
    logic [31:0]  memWriteAddress;
    logic         memWriteRequest;
    logic [31:0]  memWriteData;
    logic         memWriteDone;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    data_cache_ctrl dut (
        .clock(clock), .reset_n(reset_n),
        .reqValid(reqValid), .reqWrite(reqWrite), .reqAddr(reqAddr), .reqWdata(reqWdata),
        .reqReady(reqReady), .respValid(respValid), .respData(respData),
        .memReadAddress(memReadAddress), .memReadEnable(memReadEnable), .memLineIn(memLineIn),
        .memWriteAddress(memWriteAddress), .memWriteRequest(memWriteRequest),
        .memWriteData(memWriteData), .memWriteDone(memWriteDone)
    );

    // ---------------- dataMemory behavioural model ----------------
    logic [31:0] dev_mem [logic [29:0]];
    logic [31:0] seen_ra = 32'hFFFF_FFC0;
    int          rd_cnt = 0;
    int          fixed_lat = 0;
    int          ra_changes = 0;
    int          wr_starts = 0;
    logic [31:0] last_wa = '0;
    logic [31:0] last_wd = '0;
    logic        wreq_prev = 1'b0;
    int          wr_cnt = 0;

    function automatic logic [31:0] init_word(input logic [29:0] wa);
        logic [31:0] t;
        t = {2'b00, wa};
        return (t * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [511:0] build_line(input logic [31:0] a);
        logic [511:0] l;
        logic [29:0]  wa;
        for (int w = 0; w < 16; w++) begin
            wa = {a[31:6], w[3:0]};
            l[32*w +: 32] = dev_mem.exists(wa) ? dev_mem[wa] : init_word(wa);
        end
        return l;
    endfunction

    initial begin
        memReadEnable = 1'b1;
        memWriteDone  = 1'b1;
        memLineIn     = build_line(32'hFFFF_FFC0);
    end

    always @(posedge clock) begin
        if (memReadAddress !== seen_ra) begin
            seen_ra       <= memReadAddress;
            memReadEnable <= 1'b0;
            rd_cnt        <= (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
            ra_changes++;
        end else if (!memReadEnable) begin
            if (rd_cnt <= 1) begin
                memLineIn     <= build_line(seen_ra);
                memReadEnable <= 1'b1;
            end else begin
                rd_cnt <= rd_cnt - 1;
            end
        end
        wreq_prev <= memWriteRequest;
        if (memWriteRequest && !wreq_prev) begin
            dev_mem[memWriteAddress[31:2]] = memWriteData;
            last_wa = memWriteAddress;
            last_wd = memWriteData;
            wr_starts++;
            memWriteDone <= 1'b0;
            wr_cnt       <= int'($urandom_range(1, 4));
        end else if (!memWriteDone) begin
            if (wr_cnt <= 1) memWriteDone <= 1'b1;
            else wr_cnt <= wr_cnt - 1;
        end
    end

    // ---------------- reference model (what the LSU should observe) ----------------
    logic [31:0] ref_mem [logic [29:0]];
    bit          ref_valid [16];
    logic [21:0] ref_tag [16];
    logic [31:0] ref_last_ra = 32'hFFFF_FFC0;

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : init_word(a[31:2]);
    endfunction

    task automatic ref_reset();
        for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
        ref_last_ra = 32'hFFFF_FFC0;
    endtask

    // Predicts data, hit/miss and whether the fetch needs an address detour.
    task automatic ref_load(input logic [31:0] a, output logic [31:0] d, output bit h, output int chg);
        int i;
        i = int'(a[9:6]);
        h = ref_valid[i] && (ref_tag[i] == a[31:10]);
        chg = 0;
        if (!h) begin
            chg = ({a[31:6], 6'd0} == ref_last_ra) ? 2 : 1;
            ref_last_ra  = {a[31:6], 6'd0};
            ref_valid[i] = 1'b1;
            ref_tag[i]   = a[31:10];
        end
        d = ref_word(a);
    endtask

    // ---------------- stimulus driver ----------------
    task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat, output int dchg, output int dwr);
        int c0, w0;
        bit got;
        @(negedge clock);
        n_cmp++;
        if (reqReady !== 1'b1) begin
            n_fail++;
            $display("FAIL req_ready addr=%h: reqReady=%b required 1", a, reqReady);
        end
        c0 = ra_changes;
        w0 = wr_starts;
        reqValid = 1'b1; reqWrite = wr; reqAddr = a; reqWdata = wd;
        @(posedge clock);
        #1 reqValid = 1'b0;
        lat = 0; got = 1'b0; rd = '0;
        while (!got && lat < 200) begin
            @(negedge clock);
            lat++;
            if (respValid) begin got = 1'b1; rd = respData; end
        end
        dchg = ra_changes - c0;
        dwr  = wr_starts - w0;
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL resp_timeout addr=%h: respValid=0 after %0d cycles required 1", a, lat);
        end else begin
            @(negedge clock);
            n_cmp++;
            if (respValid !== 1'b0) begin
                n_fail++;
                $display("FAIL resp_pulse addr=%h: respValid=%b on next cycle required 0", a, respValid);
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        ref_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        n_cmp++; if (reqReady !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b required 1", reqReady); end
        n_cmp++; if (respValid !== 1'b0) begin n_fail++; $display("FAIL rst_respValid: got %b required 0", respValid); end
        n_cmp++; if (respData !== 32'd0) begin n_fail++; $display("FAIL rst_respData: got %h required 0", respData); end
        n_cmp++; if (memWriteRequest !== 1'b0) begin n_fail++; $display("FAIL rst_wreq: got %b required 0", memWriteRequest); end
        n_cmp++; if (memWriteAddress !== 32'd0) begin n_fail++; $display("FAIL rst_waddr: got %h required 0", memWriteAddress); end
        n_cmp++; if (memWriteData !== 32'd0) begin n_fail++; $display("FAIL rst_wdata: got %h required 0", memWriteData); end
        n_cmp++; if (memReadAddress !== 32'hFFFF_FFC0) begin n_fail++; $display("FAIL rst_raddr: got %h required ffffffc0", memReadAddress); end
    endtask

    task automatic test_fill_and_hit();
        logic [31:0] rd, ed; int lat, dc, dw, ec; bit eh;
        for (int k = 0; k < 2; k++) begin
            ref_load(32'h40, ed, eh, ec);
            do_req(1'b0, 32'h40, 32'd0, rd, lat, dc, dw);
            n_cmp++; if (rd !== init_word(30'd16)) begin n_fail++; $display("FAIL fill_word16 pass%0d: got %h required %h", k, rd, init_word(30'd16)); end
            n_cmp++; if ((lat == 2) !== eh) begin n_fail++; $display("FAIL fill_latency pass%0d: latency %0d, hit required %b", k, lat, eh); end
            n_cmp++; if (dc !== ec) begin n_fail++; $display("FAIL fill_fetches pass%0d: %0d address changes required %0d", k, dc, ec); end
        end
    endtask

    task automatic test_kick();
        logic [31:0] rd, ed; int lat, dc, dw, ec; bit eh;
        logic [31:0] addrs [2];
        addrs[0] = 32'h0000_0000;
        addrs[1] = 32'hFFFF_FFC4;
        for (int k = 0; k < 2; k++) begin
            apply_reset();
            ref_load(addrs[k], ed, eh, ec);
            do_req(1'b0, addrs[k], 32'd0, rd, lat, dc, dw);
            n_cmp++; if (rd !== ed) begin n_fail++; $display("FAIL kick_data addr=%h: got %h required %h", addrs[k], rd, ed); end
            n_cmp++; if (dc !== ec) begin n_fail++; $display("FAIL kick_fetches addr=%h: %0d address changes required %0d", addrs[k], dc, ec); end
        end
    endtask

    task automatic test_store_hit();
        logic [31:0] rd, ed; int lat, dc, dw, ec; bit eh;
        ref_load(32'h4, ed, eh, ec);
        do_req(1'b0, 32'h4, 32'd0, rd, lat, dc, dw);
        n_cmp++; if (rd !== ed) begin n_fail++; $display("FAIL sh_fill: got %h required %h", rd, ed); end
        ref_mem[30'd1] = 32'hDEAD_BEEF;
        do_req(1'b1, 32'h4, 32'hDEAD_BEEF, rd, lat, dc, dw);
        n_cmp++; if (dw !== 1) begin n_fail++; $display("FAIL sh_wr_count: %0d write requests required 1", dw); end
        n_cmp++; if (last_wa !== 32'h4 || last_wd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sh_wr_payload: got %h/%h required 00000004/deadbeef", last_wa, last_wd); end
        n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL sh_resp_data: got %h required 0", rd); end
        n_cmp++; if (memWriteRequest !== 1'b0) begin n_fail++; $display("FAIL sh_wreq_drop: got %b required 0", memWriteRequest); end
        ref_load(32'h4, ed, eh, ec);
        do_req(1'b0, 32'h4, 32'd0, rd, lat, dc, dw);
        n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sh_readback: got %h required deadbeef", rd); end
        n_cmp++; if (lat !== 2 || !eh) begin n_fail++; $display("FAIL sh_hit: latency %0d required 2", lat); end
    endtask

    task automatic test_store_miss();
        logic [31:0] rd, ed; int lat, dc, dw, ec; bit eh;
        ref_load(32'h0, ed, eh, ec);
        do_req(1'b0, 32'h0, 32'd0, rd, lat, dc, dw);
        ref_mem[30'h100] = 32'h1234_5678;
        do_req(1'b1, 32'h400, 32'h1234_5678, rd, lat, dc, dw);
        n_cmp++; if (dc !== 0 || dw !== 1) begin n_fail++; $display("FAIL sm_traffic: %0d fetches %0d writes required 0/1", dc, dw); end
        ref_load(32'h8, ed, eh, ec);
        do_req(1'b0, 32'h8, 32'd0, rd, lat, dc, dw);
        n_cmp++; if (lat !== 2 || rd !== ed) begin n_fail++; $display("FAIL sm_line_kept: latency %0d data %h required 2/%h", lat, rd, ed); end
        ref_load(32'h400, ed, eh, ec);
        do_req(1'b0, 32'h400, 32'd0, rd, lat, dc, dw);
        n_cmp++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL sm_refetch: got %h required 12345678", rd); end
        n_cmp++; if (lat <= 2 || dc !== ec) begin n_fail++; $display("FAIL sm_miss: latency %0d changes %0d required miss/%0d", lat, dc, ec); end
    endtask

    task automatic test_conflict();
        logic [31:0] rd, ed; int lat, dc, dw, ec; bit eh;
        logic [31:0] seq [3];
        seq[0] = 32'h0000_0000; seq[1] = 32'h0000_0400; seq[2] = 32'h0000_0000;
        for (int k = 0; k < 3; k++) begin
            ref_load(seq[k], ed, eh, ec);
            do_req(1'b0, seq[k], 32'd0, rd, lat, dc, dw);
            n_cmp++; if (rd !== ed) begin n_fail++; $display("FAIL cf_data step%0d: got %h required %h", k, rd, ed); end
            n_cmp++; if ((lat == 2) !== eh || dc !== ec) begin n_fail++; $display("FAIL cf_hitmiss step%0d: latency %0d changes %0d required hit=%b/%0d", k, lat, dc, eh, ec); end
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] rd, ed; int lat, dc, dw, ec, waited, pulses; bit eh;
        ref_load(32'h40, ed, eh, ec);
        do_req(1'b0, 32'h40, 32'd0, rd, lat, dc, dw);
        fixed_lat = 8;
        @(negedge clock);
        reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 32'h800; reqWdata = '0;
        @(posedge clock);
        #1 reqValid = 1'b0;
        waited = 0;
        while (memReadEnable && waited < 50) begin @(negedge clock); waited++; end
        n_cmp++; if (memReadEnable !== 1'b0) begin n_fail++; $display("FAIL rm_fetch_start: readEnable=%b required 0", memReadEnable); end
        repeat (2) @(negedge clock);
        pulses = 0;
        reset_n = 1'b0;
        repeat (3) begin @(negedge clock); if (respValid) pulses++; end
        reset_n = 1'b1;
        repeat (12) begin @(negedge clock); if (respValid) pulses++; end
        fixed_lat = 0;
        ref_reset();
        n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL rm_no_resp: %0d respValid pulses required 0", pulses); end
        n_cmp++; if (reqReady !== 1'b1) begin n_fail++; $display("FAIL rm_ready: got %b required 1", reqReady); end
        ref_load(32'h40, ed, eh, ec);
        do_req(1'b0, 32'h40, 32'd0, rd, lat, dc, dw);
        n_cmp++; if (lat <= 2 || rd !== ed) begin n_fail++; $display("FAIL rm_valid_cleared: latency %0d data %h required miss/%h", lat, rd, ed); end
        ref_load(32'h800, ed, eh, ec);
        do_req(1'b0, 32'h800, 32'd0, rd, lat, dc, dw);
        n_cmp++; if (rd !== ed || dc !== ec) begin n_fail++; $display("FAIL rm_after: data %h changes %0d required %h/%0d", rd, dc, ed, ec); end
    endtask

    task automatic test_random();
        logic [31:0] rd, ed, a, wd; int lat, dc, dw, ec; bit eh;
        for (int k = 0; k < 80; k++) begin
            a = 32'($urandom_range(0, 2)) * 32'h400 + 32'($urandom_range(0, 3)) * 32'h40
              + 32'($urandom_range(0, 15)) * 32'd4;
            if ($urandom_range(0, 2) == 0) begin
                wd = $urandom;
                ref_mem[a[31:2]] = wd;
                do_req(1'b1, a, wd, rd, lat, dc, dw);
                n_cmp++; if (dw !== 1 || last_wa !== a || last_wd !== wd || rd !== 32'd0) begin
                    n_fail++; $display("FAIL rnd_store %0d: wr %0d %h/%h resp %h required 1 %h/%h 0", k, dw, last_wa, last_wd, rd, a, wd);
                end
            end else begin
                ref_load(a, ed, eh, ec);
                do_req(1'b0, a, 32'd0, rd, lat, dc, dw);
                n_cmp++; if (rd !== ed) begin n_fail++; $display("FAIL rnd_load_data %0d addr=%h: got %h required %h", k, a, rd, ed); end
                n_cmp++; if ((lat == 2) !== eh || dc !== ec) begin n_fail++; $display("FAIL rnd_load_hit %0d addr=%h: latency %0d changes %0d required hit=%b/%0d", k, a, lat, dc, eh, ec); end
            end
        end
    endtask

    initial begin
        #1 reset_n = 1'b0;
        ref_reset();
        test_reset();
        test_fill_and_hit();
        test_kick();
        test_store_hit();
        test_store_miss();
        test_conflict();
        test_reset_mid_fill();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_fail);
        $fatal(1);
    end
endmodule
